// File: rtl/alu_8bit_pkg.sv
// Shared definitions for the alu_8bit handshake front-end: opcodes, FSM states
// and the ALU operand/result widths.
package alu_8bit_pkg;

   localparam int DATA_W = 8;
   localparam int RES_W  = 16;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETTLE = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

endpackage

// File: rtl/alu_op_counter.sv
// Saturating transaction counter; a clear in the same cycle as an increment wins.
module alu_op_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/alu_op_requester.sv
// Valid/ready front-end for the combinational alu_8bit: holds operands for a
// programmable settle window, captures the result and counts ops per opcode.
module alu_op_requester
   import alu_8bit_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [1:0]        cmd_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op_code,
   input  logic [RES_W-1:0]  alu_out,
   input  logic              alu_c_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_out,
   output logic              rsp_c_out,
   output logic [1:0]        rsp_op,
   output logic              busy,
   input  logic [1:0]        cnt_sel,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_val
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [3:0]        settle_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q;
   logic [1:0]        alu_op_q;
   logic [RES_W-1:0]  rsp_out_q;
   logic              rsp_c_out_q;
   logic [1:0]        rsp_op_q;
   logic              rsp_valid_q;
   logic              accept, capture;
   logic [CNT_W-1:0]  cnt_arr [4];

   assign accept  = cmd_valid && (state_q == ST_IDLE);
   assign capture = (state_q == ST_SETTLE) && (settle_q == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cmd_valid) state_d = ST_SETTLE;
         ST_SETTLE: if (settle_q == 4'd0) state_d = ST_RESP;
         ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      if (state_q == ST_IDLE) begin
         cmd_ready = 1'b1;
         busy      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_q    <= 4'd0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= 2'b00;
         rsp_out_q   <= '0;
         rsp_c_out_q <= 1'b0;
         rsp_op_q    <= 2'b00;
         rsp_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            alu_a_q  <= cmd_a;
            alu_b_q  <= cmd_b;
            alu_op_q <= cmd_op;
            settle_q <= SETTLE_INIT;
         end else if ((state_q == ST_SETTLE) && (settle_q != 4'd0)) begin
            settle_q <= settle_q - 4'd1;
         end
         // The opcode is taken from the held ALU port, not from cmd_op.
         if (capture) begin
            rsp_out_q   <= alu_out;
            rsp_c_out_q <= alu_c_out;
            rsp_op_q    <= alu_op_q;
            rsp_valid_q <= 1'b1;
         end else if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
         alu_op_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (capture && (alu_op_q == 2'(gi))),
            .clr  (cnt_clr),
            .cnt  (cnt_arr[gi])
         );
      end
   endgenerate

   assign cnt_val     = cnt_arr[cnt_sel];
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op_code = alu_op_q;
   assign rsp_out     = rsp_out_q;
   assign rsp_c_out   = rsp_c_out_q;
   assign rsp_op      = rsp_op_q;
   assign rsp_valid   = rsp_valid_q;

endmodule

// File: tb/tb_alu_op_requester.sv
// Directed bench: three requester instances (settle 1, settle 3, 2-bit counters)
// each driving a behavioural alu_8bit model.
module tb_alu_op_requester;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [3];
   logic        cmd_valid [3];
   logic        cmd_ready [3];
   logic [7:0]  cmd_a     [3];
   logic [7:0]  cmd_b     [3];
   logic [1:0]  cmd_op    [3];
   logic [7:0]  alu_a     [3];
   logic [7:0]  alu_b     [3];
   logic [1:0]  alu_op    [3];
   logic [15:0] alu_out   [3];
   logic        alu_c     [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [15:0] rsp_out   [3];
   logic        rsp_c     [3];
   logic [1:0]  rsp_op    [3];
   logic        busy      [3];
   logic [1:0]  cnt_sel   [3];
   logic        cnt_clr   [3];
   logic [15:0] cnt_val0, cnt_val1;
   logic [1:0]  cnt_val2;

   int total = 0;
   int bad   = 0;

   // alu_8bit behaviour: ADD carries out of bit 7, other ops report c_out=0.
   function automatic logic [16:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (op)
         2'b00:   return {1'b0, 8'h00, a & b};
         2'b01:   return {1'b0, 8'h00, a | b};
         2'b10:   return {s[8], 8'h00, s[7:0]};
         default: return {1'b0, {8'h00, a} * {8'h00, b}};
      endcase
   endfunction

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_alu
         assign {alu_c[gi], alu_out[gi]} = alu_model(alu_a[gi], alu_b[gi], alu_op[gi]);
      end
   endgenerate

   alu_op_requester #(.SETTLE_CYCLES(1), .CNT_W(16)) u_s1 (
      .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op_code(alu_op[0]),
      .alu_out(alu_out[0]), .alu_c_out(alu_c[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_out(rsp_out[0]),
      .rsp_c_out(rsp_c[0]), .rsp_op(rsp_op[0]), .busy(busy[0]),
      .cnt_sel(cnt_sel[0]), .cnt_clr(cnt_clr[0]), .cnt_val(cnt_val0));

   alu_op_requester #(.SETTLE_CYCLES(3), .CNT_W(16)) u_s3 (
      .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op_code(alu_op[1]),
      .alu_out(alu_out[1]), .alu_c_out(alu_c[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_out(rsp_out[1]),
      .rsp_c_out(rsp_c[1]), .rsp_op(rsp_op[1]), .busy(busy[1]),
      .cnt_sel(cnt_sel[1]), .cnt_clr(cnt_clr[1]), .cnt_val(cnt_val1));

   alu_op_requester #(.SETTLE_CYCLES(1), .CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
      .cmd_a(cmd_a[2]), .cmd_b(cmd_b[2]), .cmd_op(cmd_op[2]),
      .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_op_code(alu_op[2]),
      .alu_out(alu_out[2]), .alu_c_out(alu_c[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_out(rsp_out[2]),
      .rsp_c_out(rsp_c[2]), .rsp_op(rsp_op[2]), .busy(busy[2]),
      .cnt_sel(cnt_sel[2]), .cnt_clr(cnt_clr[2]), .cnt_val(cnt_val2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one command for a single edge; returns #1 after the accept edge.
   task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op);
      cmd_a[d]     = a;
      cmd_b[d]     = b;
      cmd_op[d]    = op;
      cmd_valid[d] = 1'b1;
      tick();
      cmd_valid[d] = 1'b0;
      $display("cmd dut=%0d a=%02h b=%02h op=%0d t=%0t", d, a, b, op, $time);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_a[i] = 8'h00; cmd_b[i] = 8'h00;
         cmd_op[i] = 2'b00; rsp_ready[i] = 1'b1; cnt_sel[i] = 2'b00; cnt_clr[i] = 1'b0;
      end
      tick(); tick();
      chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_alu_a", 32'(alu_a[0]), 32'h00);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      tick();

      // 1: single AND, settle 1
      send(0, 8'h01, 8'h01, 2'b00);
      chk("t1_valid_settle", 32'(rsp_valid[0]), 32'd0);
      chk("t1_ready_settle", 32'(cmd_ready[0]), 32'd0);
      chk("t1_busy_settle", 32'(busy[0]), 32'd1);
      tick();
      chk("t1_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t1_out", 32'(rsp_out[0]), 32'h0001);
      chk("t1_op", 32'(rsp_op[0]), 32'd0);
      tick();
      chk("t1_valid_drop", 32'(rsp_valid[0]), 32'd0);
      chk("t1_ready_back", 32'(cmd_ready[0]), 32'd1);

      // 2: back-to-back OR, ADD, MUL
      send(0, 8'h0F, 8'h0F, 2'b01);
      chk("t2_or_ready_low", 32'(cmd_ready[0]), 32'd0);
      tick();
      chk("t2_or_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t2_or_out", 32'(rsp_out[0]), 32'h000F);
      chk("t2_or_ready_resp", 32'(cmd_ready[0]), 32'd0);
      tick();
      send(0, 8'h01, 8'h01, 2'b10);
      tick();
      chk("t2_add_out", 32'(rsp_out[0]), 32'h0002);
      chk("t2_add_c", 32'(rsp_c[0]), 32'd0);
      chk("t2_add_op", 32'(rsp_op[0]), 32'd2);
      tick();
      send(0, 8'h0F, 8'h01, 2'b11);
      tick();
      chk("t2_mul_out", 32'(rsp_out[0]), 32'h000F);
      chk("t2_mul_op", 32'(rsp_op[0]), 32'd3);
      tick();
      for (int s = 0; s < 4; s++) begin
         cnt_sel[0] = 2'(s);
         #1;
         chk($sformatf("t2_cnt%0d", s), 32'(cnt_val0), 32'd1);
      end

      // 3: MUL FFxFF with response back-pressure
      rsp_ready[0] = 1'b0;
      send(0, 8'hFF, 8'hFF, 2'b11);
      tick();
      for (int k = 0; k < 5; k++) begin
         cmd_valid[0] = 1'b1; cmd_a[0] = 8'h11; cmd_b[0] = 8'h22; cmd_op[0] = 2'b00;
         chk("t3_hold_valid", 32'(rsp_valid[0]), 32'd1);
         chk("t3_hold_out", 32'(rsp_out[0]), 32'hFE01);
         chk("t3_hold_alu_a", 32'(alu_a[0]), 32'hFF);
         tick();
      end
      cmd_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      tick();
      chk("t3_release_valid", 32'(rsp_valid[0]), 32'd0);
      chk("t3_release_ready", 32'(cmd_ready[0]), 32'd1);
      chk("t3_alu_retained", 32'(alu_b[0]), 32'hFF);
      cnt_sel[0] = 2'b11; cnt_sel[0+0] = 2'b11; cnt_sel[0] = 2'b11;
      cnt_sel[0] = 2'b11;
      #1;
      chk("t3_mul_cnt", 32'(cnt_val0), 32'd2);
      cnt_sel[0] = 2'b00;
      #1;
      chk("t3_and_cnt", 32'(cnt_val0), 32'd1);

      // 4: settle 3, ADD with carry, cmd_a changed after accept
      send(1, 8'h80, 8'h90, 2'b10);
      cmd_a[1] = 8'h55;
      tick();
      chk("t4_c1_valid", 32'(rsp_valid[1]), 32'd0);
      chk("t4_c1_alu_a", 32'(alu_a[1]), 32'h80);
      tick();
      chk("t4_c2_valid", 32'(rsp_valid[1]), 32'd0);
      chk("t4_c2_alu_a", 32'(alu_a[1]), 32'h80);
      tick();
      chk("t4_valid", 32'(rsp_valid[1]), 32'd1);
      chk("t4_out", 32'(rsp_out[1]), 32'h0010);
      chk("t4_c", 32'(rsp_c[1]), 32'd1);
      chk("t4_op", 32'(rsp_op[1]), 32'd2);
      tick();
      chk("t4_idle", 32'(cmd_ready[1]), 32'd1);

      // 5: asynchronous reset during SETTLE
      cnt_sel[1] = 2'b10;
      send(1, 8'hFF, 8'h0F, 2'b11);
      #2;
      rst_n[1] = 1'b0;
      #1;
      chk("t5_alu_a", 32'(alu_a[1]), 32'h00);
      chk("t5_alu_op", 32'(alu_op[1]), 32'd0);
      chk("t5_busy", 32'(busy[1]), 32'd0);
      chk("t5_cnt", 32'(cnt_val1), 32'd0);
      chk("t5_rsp_out", 32'(rsp_out[1]), 32'h0000);
      tick();
      rst_n[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t5_no_rsp", 32'(rsp_valid[1]), 32'd0);
         chk("t5_ready", 32'(cmd_ready[1]), 32'd1);
      end

      // 6: 2-bit counter saturation and clear-wins on capture edge
      for (int n = 1; n <= 5; n++) begin
         send(2, 8'h03, 8'h05, 2'b00);
         tick();
         chk("t6_and_out", 32'(rsp_out[2]), 32'h0001);
         tick();
         chk($sformatf("t6_cnt_after_%0d", n), 32'(cnt_val2), (n < 3) ? 32'(n) : 32'd3);
      end
      send(2, 8'h03, 8'h05, 2'b00);
      cnt_clr[2] = 1'b1;
      tick();
      cnt_clr[2] = 1'b0;
      chk("t6_clr_wins", 32'(cnt_val2), 32'd0);
      chk("t6_clr_valid", 32'(rsp_valid[2]), 32'd1);
      cnt_sel[2] = 2'b01;
      #1;
      chk("t6_or_cnt", 32'(cnt_val2), 32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
